// File: rtl/apb_dma_pkg.sv
// Shared types for the APB DMA master: FSM states and completion status codes.
package apb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_ACCESS,
    WR_SETUP,
    WR_ACCESS,
    DONE
  } dma_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_RD_ERR  = 2'b01,
    ST_WR_ERR  = 2'b10,
    ST_TIMEOUT = 2'b11
  } dma_status_t;

  function automatic logic is_access(input dma_state_t s);
    return (s == RD_ACCESS) || (s == WR_ACCESS);
  endfunction

  function automatic logic is_bus_active(input dma_state_t s);
    return (s == RD_SETUP) || (s == RD_ACCESS) || (s == WR_SETUP) || (s == WR_ACCESS);
  endfunction

endpackage

// File: rtl/apb_dma_master_if.sv
// Descriptor handshake, completion status and shared APB bus of the DMA master.
interface apb_dma_master_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int NUM_TGT = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_src;
  logic [ADDR_W-1:0]         req_dst;
  logic [LEN_W-1:0]          req_len;
  logic                      req_src_inc;
  logic                      req_dst_inc;
  logic                      done;
  logic [1:0]                status;
  logic [LEN_W-1:0]          xfer_cnt;
  logic [NUM_TGT-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_TGT-1:0]        pready;
  logic [NUM_TGT-1:0]        pslverr;
  logic [NUM_TGT*DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_src, req_dst, req_len, req_src_inc, req_dst_inc,
    output req_ready, done, status, xfer_cnt,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req_valid, req_src, req_dst, req_len, req_src_inc, req_dst_inc,
    input  req_ready, done, status, xfer_cnt,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_resp_mux.sv
// Selects the addressed target's pready/pslverr/prdata; other targets are ignored.
module apb_resp_mux #(
  parameter int DATA_W  = 8,
  parameter int NUM_TGT = 2,
  parameter int TGT_W   = $clog2(NUM_TGT)
) (
  input  logic [TGT_W-1:0]          sel_i,
  input  logic [NUM_TGT-1:0]        pready_i,
  input  logic [NUM_TGT-1:0]        pslverr_i,
  input  logic [NUM_TGT*DATA_W-1:0] prdata_i,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [DATA_W-1:0]         prdata_o
);

  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_i == TGT_W'(i)) begin
        pready_o  = pready_i[i];
        pslverr_o = pslverr_i[i];
        prdata_o  = prdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_dma_master.sv
// Single-channel APB copy engine: one read then one write per word, with error and timeout abort.
module apb_dma_master
  import apb_dma_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int NUM_TGT = 2,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              nrst,
  apb_dma_master_if.master bus
);

  localparam int TGT_W  = $clog2(NUM_TGT);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dma_state_t         state_q, state_d;
  dma_status_t        status_q, status_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic               src_inc_q, src_inc_d;
  logic               dst_inc_q, dst_inc_d;
  logic [NUM_TGT-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               done_q, done_d;

  logic [TGT_W-1:0]   tgt;
  logic               pready_s, pslverr_s;
  logic [DATA_W-1:0]  prdata_s;
  logic               last_word, timeout_hit;

  // Registered address drives the decode, so the response mux follows any wrap across targets.
  assign tgt         = paddr_q[ADDR_W-1 -: TGT_W];
  assign last_word   = ({1'b0, cnt_q} + 1'b1) == {1'b0, len_q};
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  apb_resp_mux #(
    .DATA_W  (DATA_W),
    .NUM_TGT (NUM_TGT)
  ) u_resp_mux (
    .sel_i     (tgt),
    .pready_i  (bus.pready),
    .pslverr_i (bus.pslverr),
    .prdata_i  (bus.prdata),
    .pready_o  (pready_s),
    .pslverr_o (pslverr_s),
    .prdata_o  (prdata_s)
  );

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wait_d    = wait_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          src_d     = bus.req_src;
          dst_d     = bus.req_dst;
          len_d     = bus.req_len;
          src_inc_d = bus.req_src_inc;
          dst_inc_d = bus.req_dst_inc;
          cnt_d     = '0;
          status_d  = ST_OK;
          if (bus.req_len != '0) begin
            state_d = RD_SETUP;
            paddr_d = bus.req_src;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_SETUP: begin
        state_d = RD_ACCESS;
        wait_d  = '0;
      end
      RD_ACCESS: begin
        if (pready_s) begin
          pwdata_d = prdata_s;
          if (pslverr_s) begin
            state_d  = DONE;
            status_d = ST_RD_ERR;
          end else begin
            state_d = WR_SETUP;
            paddr_d = dst_q;
            if (src_inc_q) src_d = src_q + 1'b1;
          end
        end else if (timeout_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_ACCESS;
        wait_d  = '0;
      end
      WR_ACCESS: begin
        if (pready_s) begin
          if (pslverr_s) begin
            state_d  = DONE;
            status_d = ST_WR_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (dst_inc_q) dst_d = dst_q + 1'b1;
            if (last_word) begin
              state_d = DONE;
            end else begin
              state_d = RD_SETUP;
              paddr_d = src_q;
            end
          end
        end else if (timeout_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // APB controls are registered copies of what the next state requires.
    psel_d = '0;
    if (is_bus_active(state_d)) psel_d[paddr_d[ADDR_W-1 -: TGT_W]] = 1'b1;
    penable_d = is_access(state_d);
    pwrite_d  = (state_d == WR_SETUP) || (state_d == WR_ACCESS);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      status_q  <= ST_OK;
      cnt_q     <= '0;
      len_q     <= '0;
      wait_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wait_q    <= wait_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.xfer_cnt  = cnt_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: doc/apb_dma_master.md
# apb_dma_master

Parametrised single-channel APB DMA master: accepts a copy descriptor (source, destination, length, increment modes) on a valid/ready handshake and moves `len` words by alternating APB read and write transfers over one shared APB bus fanned out to `NUM_TGT` targets. Targets are decoded from the top address bits. It adds slave-error and timeout abort, fixed-address (FIFO-port) modes and a completion status pulse.

## Interface
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 8: APB data width.
- `LEN_W`, 4: descriptor length width; max `2^LEN_W-1` words.
- `NUM_TGT`, 2: APB targets, power of two, ≥2; `TGT_W = $clog2(NUM_TGT)`.
- `TIMEOUT`, 16: max ACCESS cycles without `pready` before abort; 0 disables the timeout.
- `clk` in 1: clock.
- `nrst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: descriptor valid.
- `req_ready` out 1: descriptor accepted when high with `req_valid`.
- `req_src` in ADDR_W: first source address.
- `req_dst` in ADDR_W: first destination address.
- `req_len` in LEN_W: word count.
- `req_src_inc` / `req_dst_inc` in 1: 1 increments the address per word; 0 holds it fixed.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: valid with `done`. 00 OK, 01 read slverr, 10 write slverr, 11 timeout.
- `xfer_cnt` out LEN_W: words fully written; valid with `done`.
- `psel` out NUM_TGT: one-hot target select.
- `penable`, `pwrite` out 1: shared APB control.
- `paddr` out ADDR_W; `pwdata` out DATA_W: shared.
- `pready`, `pslverr` in NUM_TGT: per-target responses.
- `prdata` in NUM_TGT*DATA_W: target i occupies `[i*DATA_W +: DATA_W]`.

## Operation
- States:
  - IDLE → RD_SETUP on handshake with `len≠0`.
  - IDLE → DONE on handshake with `len=0`.
  - RD_SETUP → RD_ACCESS.
  - RD_ACCESS → WR_SETUP on `pready & !pslverr`.
  - WR_SETUP → WR_ACCESS.
  - WR_ACCESS → RD_SETUP on `pready & !pslverr` when `cnt+1 < len`.
  - WR_ACCESS → DONE on `pready & !pslverr` when `cnt+1 = len`.
  - DONE → IDLE.
- Abort paths:
  - RD_ACCESS with `pready & pslverr` → DONE, status 01; no write is issued.
  - WR_ACCESS with `pready & pslverr` → DONE, status 10.
  - Either ACCESS state with wait counter = TIMEOUT−1 and no `pready` → DONE, status 11.
- `req_ready = (state==IDLE)`. Descriptor fields are registered on the handshake; later input changes are ignored.
- Target index is `addr[ADDR_W-1 -: TGT_W]`. `paddr` carries the full address, unmodified.
- Response (`pready`, `pslverr`, `prdata`) is muxed by the registered target index. Unselected targets' `pready`/`pslverr` are ignored.
- Address arithmetic is modulo `2^ADDR_W`. Wrap-around crosses targets: the decode follows the new address.
- `cnt` increments on each successful write; `xfer_cnt = cnt`. On a read abort it equals words completed before the failing read.
- Read data is captured on the `pready` cycle of RD_ACCESS and drives `pwdata` from WR_SETUP until the next capture.
- Reset, including mid-transfer: next cycle state=IDLE, `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `done=0`, `status=00`, `xfer_cnt=0`, cnt=0, wait counter=0.

## Timing
- All APB outputs are registered and change only on `clk` edges.
- `psel` is high in SETUP and ACCESS. `penable` is high only in ACCESS.
- `pwrite` is 0 in RD_*, 1 in WR_*. `psel` drops in DONE and IDLE.
- Zero-wait-state targets: 4 cycles per word.
  - Handshake at cycle 0 → first RD_SETUP at cycle 1.
  - `done` at cycle `4·len+1`.
  - `req_ready` high again at cycle `4·len+2`.
- Each wait state adds one cycle to its ACCESS phase.
- The wait counter clears on entry to each ACCESS state.
- `len=0`: `done` at cycle 1 with status 00, `xfer_cnt=0`.
- `pready` and a timeout on the same cycle: `pready` wins.

## Structure
- `apb_dma_pkg` holds:
  - `dma_state_t` enum: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, DONE.
  - `dma_status_t`: OK, RD_ERR, WR_ERR, TIMEOUT.
- Sub-module `apb_resp_mux`: parametrised combinational selection of `pready`/`pslverr`/`prdata` by target index.
- FSM, counters and datapath live in `apb_dma_master`.

## Test plan
- Defaults, zero-wait targets. Copy src=0x10 inc → dst=0x90 inc, len=3, memory 0x10..0x12 = A1,B2,C3. Required:
  - Writes A1,B2,C3 to 0x90..0x92 on `psel=2'b10`.
  - `done` at cycle 13, status 00, `xfer_cnt=3`.
- src=0x20 fixed, dst=0x40 inc, len=4, target 0 returns 1,2,3,4. Required: four reads of 0x20; 0x40..0x43 = 1..4.
- len=3, target 1 asserts `pslverr` on the second read. Required:
  - Exactly one write, no second write.
  - `done` with status 01, `xfer_cnt=1`.
- TIMEOUT=16, destination never asserts `pready`. Required:
  - WR_ACCESS lasts 16 cycles.
  - status 11, `xfer_cnt=0`, `psel=0` in the next cycle.
- src=0x7F inc, len=2, zero-wait. Required: second read at 0x80 selects target 1, proving wrap/decode crossing.
- `nrst` low during WR_ACCESS of a len=5 job. Required:
  - The next cycle shows all outputs at reset values and `req_ready=1`.
  - A fresh descriptor then completes correctly.
